// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register ids and processor status codes.
package y86_pkg;

    localparam logic [3:0] HALT  = 4'h0;
    localparam logic [3:0] NOP   = 4'h1;
    localparam logic [3:0] CMOV  = 4'h2;
    localparam logic [3:0] IRMOV = 4'h3;
    localparam logic [3:0] RMMOV = 4'h4;
    localparam logic [3:0] MRMOV = 4'h5;
    localparam logic [3:0] OP    = 4'h6;
    localparam logic [3:0] JXX   = 4'h7;
    localparam logic [3:0] CALL  = 4'h8;
    localparam logic [3:0] RET   = 4'h9;
    localparam logic [3:0] PUSH  = 4'hA;
    localparam logic [3:0] POP   = 4'hB;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        AOK = 3'd1,
        HLT = 3'd2,
        ADR = 3'd3,
        INS = 3'd4
    } stat_e;

endpackage

// File: rtl/y86_dst_select.sv
// Combinational destination-register decoder: icode/rA/rB/cnd -> dstE/dstM.
module y86_dst_select
    import y86_pkg::*;
(
    input  logic [3:0] in_code,
    input  logic [3:0] r_a,
    input  logic [3:0] r_b,
    input  logic       cnd,
    output logic [3:0] dst_e,
    output logic [3:0] dst_m
);

    always_comb begin
        dst_e = RNONE;
        case (in_code)
            CMOV:                   dst_e = cnd ? r_b : RNONE;
            IRMOV, OP:              dst_e = r_b;
            CALL, RET, PUSH, POP:   dst_e = RSP;
            default:                dst_e = RNONE;
        endcase
    end

    always_comb begin
        dst_m = RNONE;
        case (in_code)
            MRMOV, POP: dst_m = r_a;
            default:    dst_m = RNONE;
        endcase
    end

endmodule

// File: rtl/seq_writeback_regfile.sv
// SEQ Y86-64 write-back stage: register file, sticky status latch and retired counter.
module seq_writeback_regfile
    import y86_pkg::*;
#(
    parameter int unsigned        DATA_W   = 64,
    parameter logic [DATA_W-1:0]  RSP_INIT = DATA_W'(1023),
    parameter int unsigned        CNT_W    = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              step,
    input  logic [3:0]        in_code,
    input  logic [3:0]        r_a,
    input  logic [3:0]        r_b,
    input  logic              cnd,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] val_e,
    input  logic [DATA_W-1:0] val_m,
    input  logic              bad_mem,
    input  logic [3:0]        src_a,
    input  logic [3:0]        src_b,
    output logic [DATA_W-1:0] val_a_rd,
    output logic [DATA_W-1:0] val_b_rd,
    output logic [2:0]        stat,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam int NREGS = 15;

    logic [DATA_W-1:0] regs_q [NREGS];
    stat_e             stat_q;
    stat_e             exc;
    logic [CNT_W-1:0]  retired_q;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic              commit;

    y86_dst_select u_dst_select (
        .in_code (in_code),
        .r_a     (r_a),
        .r_b     (r_b),
        .cnd     (cnd),
        .dst_e   (dst_e),
        .dst_m   (dst_m)
    );

    always_comb begin
        exc = AOK;
        if (!instr_valid)         exc = INS;
        else if (bad_mem)         exc = ADR;
        else if (in_code == HALT) exc = HLT;
    end

    // Once status leaves AOK the whole state is frozen until reset.
    assign commit = step && (stat_q == AOK);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (4'(i) == RSP) ? RSP_INIT : '0;
            end
            stat_q    <= AOK;
            retired_q <= '0;
        end else if (commit) begin
            if (exc == AOK) begin
                // dstM takes precedence so popq %rsp keeps the loaded value.
                for (int i = 0; i < NREGS; i++) begin
                    if (4'(i) == dst_m)      regs_q[i] <= val_m;
                    else if (4'(i) == dst_e) regs_q[i] <= val_e;
                end
                retired_q <= retired_q + CNT_W'(1);
            end else begin
                stat_q <= exc;
            end
        end
    end

    // Reads see pre-edge contents; there is no write-to-read bypass.
    always_comb begin
        val_a_rd = '0;
        if (src_a != RNONE) val_a_rd = regs_q[src_a];
    end

    always_comb begin
        val_b_rd = '0;
        if (src_b != RNONE) val_b_rd = regs_q[src_b];
    end

    assign stat    = stat_q;
    assign halted  = (stat_q != AOK);
    assign retired = retired_q;

endmodule

// File: tb/tb_seq_writeback_regfile.sv
// Scoreboard bench for seq_writeback_regfile: stimulus queues expectations, a monitor checks them.
module tb_seq_writeback_regfile;

    logic        clock = 1'b0;
    logic        reset;
    logic        step;
    logic [3:0]  in_code;
    logic [3:0]  r_a;
    logic [3:0]  r_b;
    logic        cnd;
    logic        instr_valid;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic        bad_mem;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [63:0] val_a_rd;
    logic [63:0] val_b_rd;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] retired;

    seq_writeback_regfile dut (
        .clock       (clock),
        .reset       (reset),
        .step        (step),
        .in_code     (in_code),
        .r_a         (r_a),
        .r_b         (r_b),
        .cnd         (cnd),
        .instr_valid (instr_valid),
        .val_e       (val_e),
        .val_m       (val_m),
        .bad_mem     (bad_mem),
        .src_a       (src_a),
        .src_b       (src_b),
        .val_a_rd    (val_a_rd),
        .val_b_rd    (val_b_rd),
        .stat        (stat),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    localparam int KRegA = 0;
    localparam int KRegB = 1;
    localparam int KStat = 2;
    localparam int KHalt = 3;
    localparam int KRet  = 4;

    typedef struct {
        int          kind;
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input int kind, input string name, input logic [63:0] v);
        exp_t e;
        e.kind = kind;
        e.name = name;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Monitor: every negedge, compare all expectations queued during this cycle.
    initial begin
        forever begin
            @(negedge clock);
            while (sb.size() > 0) begin
                exp_t        e;
                logic [63:0] act;
                e = sb.pop_front();
                case (e.kind)
                    KRegA:   act = val_a_rd;
                    KRegB:   act = val_b_rd;
                    KStat:   act = {61'd0, stat};
                    KHalt:   act = {63'd0, halted};
                    default: act = retired;
                endcase
                checks++;
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [3:0] ra, input logic [3:0] rb,
                         input logic cn, input logic [63:0] ve, input logic [63:0] vm,
                         input logic bm, input logic iv, input logic stp);
        @(posedge clock);
        #1;
        step = stp; in_code = c; r_a = ra; r_b = rb; cnd = cn;
        val_e = ve; val_m = vm; bad_mem = bm; instr_valid = iv;
    endtask

    task automatic chk_reg(input logic [3:0] idx, input logic [63:0] v, input string name);
        @(posedge clock);
        #1;
        step  = 1'b0;
        src_a = idx;
        push(KRegA, name, v);
    endtask

    task automatic chk(input int kind, input logic [63:0] v, input string name);
        @(posedge clock);
        #1;
        step = 1'b0;
        push(kind, name, v);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        step  = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; step = 1'b0; in_code = 4'h1; r_a = 4'hF; r_b = 4'hF; cnd = 1'b0;
        instr_valid = 1'b1; val_e = '0; val_m = '0; bad_mem = 1'b0; src_a = 4'h0; src_b = 4'hF;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        chk_reg(4'h4, 64'd1023, "rst_reg4");
        chk_reg(4'h0, 64'd0, "rst_reg0");
        chk_reg(4'hE, 64'd0, "rst_reg14");
        chk_reg(4'hF, 64'd0, "rst_rdA_F");
        chk(KRegB, 64'd0, "rst_rdB_F");
        chk(KStat, 64'd1, "rst_stat");
        chk(KHalt, 64'd0, "rst_halted");
        chk(KRet, 64'd0, "rst_retired");

        // irmovq $0x55, %rdx with same-cycle read of the old value
        issue(4'h3, 4'hF, 4'h2, 1'b0, 64'h55, 64'h0, 1'b0, 1'b1, 1'b1);
        src_a = 4'h2;
        push(KRegA, "irmov_old_read", 64'd0);
        chk_reg(4'h2, 64'h55, "irmov_reg2");
        chk(KRet, 64'd1, "irmov_retired");

        // cmov not taken, then taken
        issue(4'h2, 4'hF, 4'h3, 1'b0, 64'd7, 64'h0, 1'b0, 1'b1, 1'b1);
        chk_reg(4'h3, 64'd0, "cmov_nt_reg3");
        chk(KRet, 64'd2, "cmov_nt_retired");
        issue(4'h2, 4'hF, 4'h3, 1'b1, 64'd7, 64'h0, 1'b0, 1'b1, 1'b1);
        chk_reg(4'h3, 64'd7, "cmov_t_reg3");
        chk(KRet, 64'd3, "cmov_t_retired");

        // popq %rsp: val_m wins over val_e
        issue(4'hB, 4'h4, 4'hF, 1'b0, 64'd1024, 64'hAB, 1'b0, 1'b1, 1'b1);
        chk_reg(4'h4, 64'hAB, "pop_rsp_reg4");
        // popq %rbx
        issue(4'hB, 4'h3, 4'hF, 1'b0, 64'd1024, 64'hAB, 1'b0, 1'b1, 1'b1);
        chk_reg(4'h3, 64'hAB, "pop_rbx_reg3");
        chk_reg(4'h4, 64'd1024, "pop_rbx_reg4");
        chk(KRet, 64'd5, "pop_retired");

        // step=0 holds everything
        issue(4'h3, 4'hF, 4'h2, 1'b0, 64'h99, 64'h0, 1'b0, 1'b1, 1'b0);
        chk_reg(4'h2, 64'h55, "hold_reg2");
        chk(KRet, 64'd5, "hold_retired");

        // Out-of-range icode retires as a no-op
        issue(4'hC, 4'h2, 4'h2, 1'b1, 64'h77, 64'h88, 1'b0, 1'b1, 1'b1);
        chk_reg(4'h2, 64'h55, "icode12_reg2");
        chk(KRet, 64'd6, "icode12_retired");

        // OP writes rB; write to F is dropped
        issue(4'h6, 4'h1, 4'h5, 1'b0, 64'h1234, 64'h0, 1'b0, 1'b1, 1'b1);
        chk_reg(4'h5, 64'h1234, "op_reg5");
        issue(4'h3, 4'hF, 4'hF, 1'b0, 64'h77, 64'h0, 1'b0, 1'b1, 1'b1);
        chk_reg(4'hE, 64'd0, "wrF_reg14");
        chk_reg(4'hF, 64'd0, "wrF_rdF");
        chk(KRet, 64'd8, "wrF_retired");

        // INS beats ADR; nothing written, state frozen afterwards
        issue(4'h5, 4'h6, 4'h4, 1'b0, 64'h10, 64'h20, 1'b1, 1'b0, 1'b1);
        chk(KStat, 64'd4, "ins_stat");
        chk(KHalt, 64'd1, "ins_halted");
        chk(KRet, 64'd8, "ins_retired");
        chk_reg(4'h6, 64'd0, "ins_reg6");
        issue(4'h3, 4'hF, 4'h2, 1'b0, 64'h66, 64'h0, 1'b0, 1'b1, 1'b1);
        chk_reg(4'h2, 64'h55, "ins_frozen_reg2");
        chk(KRet, 64'd8, "ins_frozen_retired");
        chk(KStat, 64'd4, "ins_frozen_stat");

        do_reset();
        chk(KStat, 64'd1, "rst2_stat");
        chk(KRet, 64'd0, "rst2_retired");
        chk_reg(4'h2, 64'd0, "rst2_reg2");
        chk_reg(4'h4, 64'd1023, "rst2_reg4");

        // ADR beats HLT
        issue(4'h0, 4'h6, 4'hF, 1'b0, 64'h0, 64'h20, 1'b1, 1'b1, 1'b1);
        chk(KStat, 64'd3, "adr_stat");
        chk(KRet, 64'd0, "adr_retired");

        // Reset during an active step: instruction not committed
        @(posedge clock);
        #1;
        reset = 1'b1; step = 1'b1; in_code = 4'h3; r_b = 4'h2; val_e = 64'h42;
        bad_mem = 1'b0; instr_valid = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0; step = 1'b0;
        chk_reg(4'h2, 64'd0, "rststep_reg2");
        chk(KRet, 64'd0, "rststep_retired");
        chk(KStat, 64'd1, "rststep_stat");

        // Halt then ten ignored steps
        issue(4'h3, 4'hF, 4'h1, 1'b0, 64'h11, 64'h0, 1'b0, 1'b1, 1'b1);
        issue(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);
        chk(KStat, 64'd2, "halt_stat");
        chk(KHalt, 64'd1, "halt_halted");
        chk(KRet, 64'd1, "halt_retired");
        for (int i = 0; i < 10; i++) begin
            issue(4'hB, 4'h1, 4'hF, 1'b0, 64'h22, 64'h33, 1'b0, 1'b1, 1'b1);
        end
        chk_reg(4'h1, 64'h11, "halt_frozen_reg1");
        chk_reg(4'h4, 64'd1023, "halt_frozen_reg4");
        chk(KRet, 64'd1, "halt_frozen_retired");
        chk(KStat, 64'd2, "halt_frozen_stat");

        repeat (2) @(posedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
